// File: rtl/fetch_redirect_arb.sv
// Frontend PC redirect arbiter: picks COMM > BU > EJ, holds the winner in a
// one-entry slot toward PC generation, and strobes the frontend/backend flushes.
module fetch_redirect_arb #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            comm_valid_i,
  input  logic [XLEN-1:0] comm_target_i,
  input  logic            bu_valid_i,
  input  logic [XLEN-1:0] bu_target_i,
  input  logic            ej_valid_i,
  input  logic [XLEN-1:0] ej_base_i,
  input  logic [XLEN-1:0] ej_offs_i,
  output logic            ej_ack_o,
  input  logic            pcgen_ready_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_target_o,
  output logic [1:0]      redir_src_o,
  output logic            fe_flush_o,
  output logic            be_flush_o
);

  localparam logic [1:0] SRC_EJ   = 2'd0;
  localparam logic [1:0] SRC_BU   = 2'd1;
  localparam logic [1:0] SRC_COMM = 2'd2;

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [1:0]      src_q, src_d;

  logic            xfer;
  logic            win_valid;
  logic [1:0]      win_src;
  logic [XLEN-1:0] win_target;
  logic [XLEN-1:0] ej_target;

  assign ej_target      = ej_base_i + ej_offs_i;
  assign redir_valid_o  = (state_q == FULL);
  assign redir_target_o = target_q;
  assign redir_src_o    = src_q;
  assign xfer           = redir_valid_o && pcgen_ready_i;
  assign fe_flush_o     = xfer && (src_q != SRC_EJ);
  assign be_flush_o     = xfer && (src_q == SRC_COMM);

  // An EJ request seen while a flush is leaving is on the wrong path, so it loses.
  always_comb begin
    win_valid  = 1'b0;
    win_src    = SRC_EJ;
    win_target = '0;
    if (comm_valid_i) begin
      win_valid  = 1'b1;
      win_src    = SRC_COMM;
      win_target = comm_target_i;
    end else if (bu_valid_i) begin
      win_valid  = 1'b1;
      win_src    = SRC_BU;
      win_target = bu_target_i;
    end else if (ej_valid_i && !fe_flush_o) begin
      win_valid  = 1'b1;
      win_src    = SRC_EJ;
      win_target = ej_target;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    src_d    = src_q;
    ej_ack_o = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (win_valid) begin
          state_d  = FULL;
          target_d = win_target;
          src_d    = win_src;
          ej_ack_o = (win_src == SRC_EJ);
        end
      end
      FULL: begin
        if (xfer) begin
          if (win_valid) begin
            target_d = win_target;
            src_d    = win_src;
            ej_ack_o = (win_src == SRC_EJ);
          end else begin
            state_d = EMPTY;
          end
        end else if (win_valid && (win_src > src_q)) begin
          // Strictly higher priority supersedes the pending redirect.
          target_d = win_target;
          src_d    = win_src;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      target_q <= '0;
      src_q    <= SRC_EJ;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      src_q    <= src_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_arb.sv
// Self-checking bench for fetch_redirect_arb: directed scenarios followed by
// random traffic, all compared against a priority/slot reference model.
module tb_fetch_redirect_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        comm_valid_i = 1'b0;
  logic [63:0] comm_target_i = '0;
  logic        bu_valid_i = 1'b0;
  logic [63:0] bu_target_i = '0;
  logic        ej_valid_i = 1'b0;
  logic [63:0] ej_base_i = '0;
  logic [63:0] ej_offs_i = '0;
  logic        ej_ack_o;
  logic        pcgen_ready_i = 1'b0;
  logic        redir_valid_o;
  logic [63:0] redir_target_o;
  logic [1:0]  redir_src_o;
  logic        fe_flush_o;
  logic        be_flush_o;

  int checks = 0;
  int errors = 0;

  // Reference slot: occupied flag, target and source priority (2 COMM, 1 BU, 0 EJ).
  bit          mValid = 0;
  logic [63:0] mTarget = '0;
  int          mSrc = 0;
  bit          lastAck = 0;

  fetch_redirect_arb #(.XLEN(64)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .comm_valid_i   (comm_valid_i),
    .comm_target_i  (comm_target_i),
    .bu_valid_i     (bu_valid_i),
    .bu_target_i    (bu_target_i),
    .ej_valid_i     (ej_valid_i),
    .ej_base_i      (ej_base_i),
    .ej_offs_i      (ej_offs_i),
    .ej_ack_o       (ej_ack_o),
    .pcgen_ready_i  (pcgen_ready_i),
    .redir_valid_o  (redir_valid_o),
    .redir_target_o (redir_target_o),
    .redir_src_o    (redir_src_o),
    .fe_flush_o     (fe_flush_o),
    .be_flush_o     (be_flush_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model, then
  // advances the model and the clock. Called just after a rising edge.
  task automatic applyStimulus(input bit c, input logic [63:0] ct, input bit b,
                               input logic [63:0] bt, input bit e, input logic [63:0] eb,
                               input logic [63:0] eo, input bit rdy);
    bit          xfer, feExp, beExp, hasWin, ackExp;
    int          wPri;
    logic [63:0] wTgt;
    comm_valid_i = c;  comm_target_i = ct;
    bu_valid_i = b;    bu_target_i = bt;
    ej_valid_i = e;    ej_base_i = eb;  ej_offs_i = eo;
    pcgen_ready_i = rdy;
    #3;
    xfer  = mValid && rdy;
    feExp = xfer && mSrc != 0;
    beExp = xfer && mSrc == 2;
    hasWin = 1; wPri = 0; wTgt = '0;
    if (c) begin wPri = 2; wTgt = ct; end
    else if (b) begin wPri = 1; wTgt = bt; end
    else if (e && !feExp) begin wPri = 0; wTgt = eb + eo; end
    else hasWin = 0;
    ackExp = hasWin && wPri == 0 && (!mValid || xfer);
    checkOutput("redir_valid", 64'(redir_valid_o), 64'(mValid));
    if (mValid) begin
      checkOutput("redir_target", redir_target_o, mTarget);
      checkOutput("redir_src", 64'(redir_src_o), 64'(mSrc));
    end
    checkOutput("fe_flush", 64'(fe_flush_o), 64'(feExp));
    checkOutput("be_flush", 64'(be_flush_o), 64'(beExp));
    checkOutput("ej_ack", 64'(ej_ack_o), 64'(ackExp));
    lastAck = ackExp;
    if (hasWin && (!mValid || xfer || wPri > mSrc)) begin
      mValid = 1; mTarget = wTgt; mSrc = wPri;
    end else if (xfer) begin
      mValid = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(0, '0, 0, '0, 0, '0, '0, rdy);
  endtask

  initial begin
    bit          ejHeld;
    logic [63:0] hb, ho;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_valid", 64'(redir_valid_o), 64'd0);
    checkOutput("reset_target", redir_target_o, 64'd0);
    checkOutput("reset_src", 64'(redir_src_o), 64'd0);
    checkOutput("reset_flush", 64'({fe_flush_o, be_flush_o, ej_ack_o}), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] EJ wrap-around target");
    applyStimulus(0, '0, 0, '0, 1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1);
    checkOutput("ej_first_target", redir_target_o, 64'hFF0);
    idle(1);
    idle(1);

    $display("[TB] BU held by stall");
    applyStimulus(0, '0, 1, 64'h2000, 0, '0, '0, 0);
    repeat (3) idle(0);
    idle(1);
    idle(1);

    $display("[TB] COMM supersedes held BU");
    applyStimulus(0, '0, 1, 64'h2000, 0, '0, '0, 0);
    applyStimulus(1, 64'h3000, 0, '0, 0, '0, '0, 0);
    checkOutput("comm_override", redir_target_o, 64'h3000);
    idle(1);
    idle(1);

    $display("[TB] EJ blocked behind BU transfer");
    applyStimulus(0, '0, 1, 64'h2000, 0, '0, '0, 0);
    repeat (2) applyStimulus(0, '0, 0, '0, 1, 64'h400, 64'h20, 0);
    applyStimulus(0, '0, 0, '0, 1, 64'h400, 64'h20, 1);
    applyStimulus(0, '0, 0, '0, 1, 64'h400, 64'h20, 1);
    checkOutput("ej_after_bu", redir_target_o, 64'h420);
    idle(1);

    $display("[TB] simultaneous requests");
    applyStimulus(1, 64'h5000, 1, 64'h6000, 1, 64'h10, 64'h10, 0);
    idle(1);
    idle(1);

    $display("[TB] reset while full");
    applyStimulus(0, '0, 1, 64'h7000, 0, '0, '0, 0);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 64'(redir_valid_o), 64'd0);
    checkOutput("rst_mid_target", redir_target_o, 64'd0);
    checkOutput("rst_mid_flush", 64'({fe_flush_o, be_flush_o}), 64'd0);
    mValid = 0; mTarget = '0; mSrc = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(1);
    idle(1);

    $display("[TB] random traffic");
    ejHeld = 0; hb = '0; ho = '0;
    for (int i = 0; i < 3000; i++) begin
      bit c, b, r;
      c = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) != 0);
      if (!ejHeld && $urandom_range(0, 2) == 0) begin
        ejHeld = 1;
        hb = {$urandom, $urandom};
        ho = {$urandom, $urandom};
      end
      applyStimulus(c, {$urandom, $urandom}, b, {$urandom, $urandom},
                    ejHeld, hb, ho, r);
      if (lastAck) ejHeld = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
